// File: rtl/regfile_writeback.sv
// Writeback buffer owning the register file write port: in-order FIFO fed by load and ALU producers.
// Optional macro WB_BYPASS_EN enables the youngest-entry forwarding mux on fwd1/fwd2.
module regfile_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [ADDR_WIDTH-1:0]    alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  output logic                     alu_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_WIDTH-1:0]    ld_rd,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  output logic                     ld_ready,
  output logic [ADDR_WIDTH-1:0]    A3,
  output logic [DATA_WIDTH-1:0]    WD3,
  output logic                     WE3,
  input  logic [ADDR_WIDTH-1:0]    A1,
  input  logic [ADDR_WIDTH-1:0]    A2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [DATA_WIDTH-1:0]    fwd1,
  output logic [DATA_WIDTH-1:0]    fwd2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] rd_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]      valid_reg;
  logic [PTR_W-1:0]      rd_ptr_reg, wr_ptr_reg;
  logic [CNT_W-1:0]      count_reg;

  logic                  nonempty;
  logic                  pop;
  logic [CNT_W-1:0]      free;
  logic                  push_ld, push_alu;
  logic [PTR_W-1:0]      ld_idx, alu_idx;
  logic [PTR_W-1:0]      rd_ptr_next, wr_ptr_next;
  logic [CNT_W-1:0]      count_next;
  logic [DEPTH-1:0]      slot_ld_we, slot_alu_we, slot_pop;
  logic [DEPTH-1:0]      match1, match2;

  assign nonempty = (count_reg != '0);
  assign pop      = nonempty & ~reset;

  // A pop this cycle hands its slot straight back to the producers.
  assign free = CNT_W'(DEPTH) - count_reg + CNT_W'(nonempty);

  // Nothing is accepted while reset is held.
  assign ld_ready  = (free >= CNT_W'(1)) & ~reset;
  assign alu_ready = ((free >= CNT_W'(2)) | ((free >= CNT_W'(1)) & ~ld_valid)) & ~reset;

  // x0 writes finish their handshake but never occupy a slot.
  assign push_ld  = ld_valid  & ld_ready  & (ld_rd  != '0);
  assign push_alu = alu_valid & alu_ready & (alu_rd != '0);

  // The load is enqueued first, so a simultaneous ALU result lands one slot later.
  assign ld_idx  = wr_ptr_reg;
  assign alu_idx = wr_ptr_reg + PTR_W'(push_ld);

  assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
  assign wr_ptr_next = wr_ptr_reg + PTR_W'(push_ld) + PTR_W'(push_alu);
  assign count_next  = count_reg - CNT_W'(pop) + CNT_W'(push_ld) + CNT_W'(push_alu);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_ld_we[gi]  = push_ld  & (ld_idx  == PTR_W'(gi));
      assign slot_alu_we[gi] = push_alu & (alu_idx == PTR_W'(gi));
      assign slot_pop[gi]    = pop      & (rd_ptr_reg == PTR_W'(gi));
      assign match1[gi]      = valid_reg[gi] & (rd_mem[gi] == A1);
      assign match2[gi]      = valid_reg[gi] & (rd_mem[gi] == A2);
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_ld_we[i]) begin
        rd_mem[i]   <= ld_rd;
        data_mem[i] <= ld_data;
      end else if (slot_alu_we[i]) begin
        rd_mem[i]   <= alu_rd;
        data_mem[i] <= alu_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      // A full queue can pop and refill the same slot; the refill must win.
      valid_reg  <= (valid_reg & ~slot_pop) | slot_ld_we | slot_alu_we;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  assign count = count_reg;
  assign WE3   = nonempty & ~reset;
  assign A3    = WE3 ? rd_mem[rd_ptr_reg]   : '0;
  assign WD3   = WE3 ? data_mem[rd_ptr_reg] : '0;

  // Scan oldest to youngest so the last match seen is the youngest pending value.
  logic                  any1, any2;
  logic [DATA_WIDTH-1:0] young1, young2;
  logic [PTR_W-1:0]      scan_idx;

  always_comb begin
    any1     = 1'b0;
    any2     = 1'b0;
    young1   = '0;
    young2   = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_ptr_reg + PTR_W'(k);
      if (match1[scan_idx]) begin
        any1   = 1'b1;
        young1 = data_mem[scan_idx];
      end
      if (match2[scan_idx]) begin
        any2   = 1'b1;
        young2 = data_mem[scan_idx];
      end
    end
  end

  assign hit1 = any1 & (A1 != '0);
  assign hit2 = any2 & (A2 != '0);

`ifdef WB_BYPASS_EN
  assign fwd1 = hit1 ? young1 : '0;
  assign fwd2 = hit2 ? young2 : '0;
`else
  // Decode only stalls on hits in this build; the data path is left out.
  assign fwd1 = '0;
  assign fwd2 = '0;
  logic unused_young;
  assign unused_young = ^{young1, young2};
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed table, hand sequences, and random traffic vs a queue model.
module tb_regfile_writeback;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, ld_valid;
  logic [4:0]  alu_rd, ld_rd, A1, A2, A3;
  logic [31:0] alu_data, ld_data, WD3, fwd1, fwd2;
  logic        alu_ready, ld_ready, WE3, hit1, hit2;
  logic [2:0]  count;

  regfile_writeback #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .A3(A3), .WD3(WD3), .WE3(WE3), .A1(A1), .A2(A2),
    .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2), .count(count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending writes, oldest at index 0.
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t mq[$];

  int          e_cnt;
  logic        e_we, e_h1, e_h2, e_ldr, e_alur;
  logic [4:0]  e_a3;
  logic [31:0] e_wd, e_f1, e_f2;

  task automatic model_eval();
    int fr;
    e_cnt = mq.size();
    e_we  = (e_cnt != 0) && !reset;
    e_a3  = (e_cnt != 0) ? mq[0].rd : 5'd0;
    e_wd  = (e_cnt != 0) ? mq[0].d  : 32'd0;
    e_h1 = 0; e_h2 = 0; e_f1 = 0; e_f2 = 0;
    foreach (mq[i]) begin
      if (A1 != 0 && mq[i].rd == A1) begin e_h1 = 1; e_f1 = mq[i].d; end
      if (A2 != 0 && mq[i].rd == A2) begin e_h2 = 1; e_f2 = mq[i].d; end
    end
    if (!BYP) begin e_f1 = 0; e_f2 = 0; end
    fr     = DEPTH - e_cnt + ((e_cnt != 0) ? 1 : 0);
    e_ldr  = (fr >= 1);
    e_alur = (fr >= 2) || (fr >= 1 && !ld_valid);
  endtask

  task automatic model_check();
    chk("count", 32'(count), 32'(e_cnt));
    chk("WE3", 32'(WE3), 32'(e_we));
    if (!reset) begin
      chk("A3", 32'(A3), 32'(e_a3));
      chk("WD3", WD3, e_wd);
      chk("hit1", 32'(hit1), 32'(e_h1));
      chk("hit2", 32'(hit2), 32'(e_h2));
      chk("fwd1", fwd1, e_f1);
      chk("fwd2", fwd2, e_f2);
      chk("ld_ready", 32'(ld_ready), 32'(e_ldr));
      chk("alu_ready", 32'(alu_ready), 32'(e_alur));
    end
  endtask

  // Applies the edge: inputs are still those evaluated in model_eval.
  task automatic model_advance(input logic rst, input logic lv, input logic [4:0] lrd,
                               input logic [31:0] ld, input logic av, input logic [4:0] ard,
                               input logic [31:0] ad);
    if (rst) begin
      mq.delete();
    end else begin
      if (mq.size() != 0) void'(mq.pop_front());
      if (lv && e_ldr && lrd != 0) mq.push_back('{rd: lrd, d: ld});
      if (av && e_alur && ard != 0) mq.push_back('{rd: ard, d: ad});
    end
  endtask

  // Inputs are set at the falling edge; outputs sampled 1 time unit later.
  task automatic run_cycle(input bit do_check);
    logic rst_s, lv_s, av_s;
    logic [4:0] lrd_s, ard_s;
    logic [31:0] ld_s, ad_s;
    #1;
    model_eval();
    if (do_check) model_check();
    rst_s = reset; lv_s = ld_valid; lrd_s = ld_rd; ld_s = ld_data;
    av_s = alu_valid; ard_s = alu_rd; ad_s = alu_data;
    @(posedge clk);
    model_advance(rst_s, lv_s, lrd_s, ld_s, av_s, ard_s, ad_s);
    @(negedge clk);
  endtask

  task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input logic [4:0] a1, input logic [4:0] a2);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid = lv; ld_rd = lrd; ld_data = ld;
    A1 = a1; A2 = a2;
  endtask

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic lv; logic [4:0] lrd; logic [31:0] ld;
    logic [4:0] a1, a2;
    int cnt; logic we; logic [4:0] a3; logic [31:0] wd;
    logic h1, h2; logic [31:0] f1; logic ardy, lrdy;
  } vec_t;

  vec_t tbl[9];
  int   max_cnt;

  initial begin
    // in: alu v/rd/data, ld v/rd/data, A1, A2 | out: count, WE3, A3, WD3, hit1, hit2, fwd1(bypass), alu_ready, ld_ready
    tbl[0] = '{1, 5, 32'h1234, 0, 0, 0,    5, 0, 0, 0, 0, 0,        0, 0, 0,        1, 1};
    tbl[1] = '{0, 0, 0,        0, 0, 0,    5, 5, 1, 1, 5, 32'h1234, 1, 1, 32'h1234, 1, 1};
    tbl[2] = '{0, 0, 0,        0, 0, 0,    5, 6, 0, 0, 0, 0,        0, 0, 0,        1, 1};
    tbl[3] = '{1, 3, 32'hBB,   1, 3, 32'hAA, 3, 0, 0, 0, 0, 0,      0, 0, 0,        1, 1};
    tbl[4] = '{0, 0, 0,        0, 0, 0,    3, 4, 2, 1, 3, 32'hAA,   1, 0, 32'hBB,   1, 1};
    tbl[5] = '{0, 0, 0,        0, 0, 0,    3, 3, 1, 1, 3, 32'hBB,   1, 1, 32'hBB,   1, 1};
    tbl[6] = '{1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0,      0, 0, 0,        1, 1};
    tbl[7] = '{0, 0, 0,        0, 0, 0,    0, 0, 0, 0, 0, 0,        0, 0, 0,        1, 1};
    tbl[8] = '{0, 0, 0,        0, 0, 0,    0, 0, 0, 0, 0, 0,        0, 0, 0,        1, 1};

    reset = 1'b1;
    set_in(1, 4, 32'hDEAD, 1, 6, 32'hBEEF, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_WE3", 32'(WE3), 0);
    chk("rst_A3", 32'(A3), 0);
    chk("rst_WD3", WD3, 0);
    chk("rst_hit", 32'({hit1, hit2}), 0);
    chk("rst_fwd", fwd1 | fwd2, 0);
    chk("rst_ready", 32'({ld_ready, alu_ready}), 32'h3);
    mq.delete();
    run_cycle(1);

    foreach (tbl[i]) begin
      set_in(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lrd, tbl[i].ld, tbl[i].a1, tbl[i].a2);
      #1;
      $display("vec %0d: count=%0d WE3=%0b A3=%0d WD3=0x%0h hit1=%0b fwd1=0x%0h", i, count, WE3, A3, WD3, hit1, fwd1);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_WE3", i), 32'(WE3), 32'(tbl[i].we));
      chk($sformatf("v%0d_A3", i), 32'(A3), 32'(tbl[i].a3));
      chk($sformatf("v%0d_WD3", i), WD3, tbl[i].wd);
      chk($sformatf("v%0d_hit1", i), 32'(hit1), 32'(tbl[i].h1));
      chk($sformatf("v%0d_hit2", i), 32'(hit2), 32'(tbl[i].h2));
      chk($sformatf("v%0d_fwd1", i), fwd1, BYP ? tbl[i].f1 : 32'd0);
      chk($sformatf("v%0d_alu_ready", i), 32'(alu_ready), 32'(tbl[i].ardy));
      chk($sformatf("v%0d_ld_ready", i), 32'(ld_ready), 32'(tbl[i].lrdy));
      run_cycle(0);
    end

    // Back-pressure: both producers valid for 8 cycles with distinct rd/data.
    max_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      set_in(1, 5'(2*i+1), 32'hA000 + 32'(i), 1, 5'(2*i+2), 32'hB000 + 32'(i), 5'(2*i+1), 5'(2*i));
      #1;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      $display("bp %0d: count=%0d ld_ready=%0b alu_ready=%0b WD3=0x%0h", i, count, ld_ready, alu_ready, WD3);
      run_cycle(1);
    end
    chk("bp_saturate", 32'(max_cnt), DEPTH);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) run_cycle(1);

    // Reset mid-stream with three entries queued.
    set_in(1, 8, 32'h80, 1, 7, 32'h70, 0, 0);
    run_cycle(1);
    set_in(1, 10, 32'hA0, 1, 9, 32'h90, 0, 0);
    run_cycle(1);
    set_in(0, 0, 0, 0, 0, 0, 9, 10);
    #1;
    chk("pre_rst_count", 32'(count), 3);
    reset = 1'b1;
    set_in(1, 11, 32'hB1, 1, 12, 32'hC1, 9, 10);
    run_cycle(1);
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 9, 10);
    #1;
    $display("post reset: count=%0d WE3=%0b hit1=%0b hit2=%0b", count, WE3, hit1, hit2);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_WE3", 32'(WE3), 0);
    chk("mid_rst_hit", 32'({hit1, hit2}), 0);
    for (int i = 0; i < 4; i++) run_cycle(1);

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) == 0);
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      run_cycle(1);
    end
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) run_cycle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
